// File: rtl/mux_sel_rr_arbiter_if.sv
// Handshake bundle between the four requesters, the arbiter
// and the downstream consumer of the 4:1 data mux.
interface mux_sel_rr_arbiter_if;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] ack;

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output out_valid,
    output ack
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  out_valid,
    input  ack
  );
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter driving the sel input of a 4:1 data mux.
// Holds a grant until accepted; served source is masked on transfer.
module mux_sel_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int PRIO_RESET = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_sel_rr_arbiter_if.master bus
);

  if (N_REQ != 4) begin : g_bad_n_req
    $error("mux_sel_rr_arbiter: N_REQ must be 4");
  end

  localparam logic [1:0] P_RST = 2'(PRIO_RESET);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [3:0] w_cand;
  logic       w_xfer;

  // First set bit of v, scanning start, start+1, ... mod 4.
  function automatic logic [1:0] f_search(
    input logic [3:0] v,
    input logic [1:0] start
  );
    logic [1:0] idx;
    logic       hit;
    f_search = start;
    hit      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!hit && v[idx]) begin
        f_search = idx;
        hit      = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_ptr   <= P_RST;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cand      = bus.req & ~(4'b0001 << r_sel);
    unique case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_state_nxt = S_GRANT;
          w_sel_nxt   = f_search(bus.req, r_ptr);
        end
      end
      S_GRANT: begin
        if (bus.out_ready) begin
          w_ptr_nxt = r_sel + 2'd1;
          if (|w_cand) begin
            w_sel_nxt = f_search(w_cand, r_sel + 2'd1);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.out_valid = (r_state == S_GRANT);
    bus.sel       = r_sel;
    w_xfer        = bus.out_valid & bus.out_ready;
    bus.ack       = 4'b0000;
    if (w_xfer) begin
      bus.ack = 4'b0001 << r_sel;
    end
  end

endmodule
